// File: rtl/rx_buf_pkg.sv
// Shared types, widths and the read-lane extraction helper for the RX frame slot buffer.
package rx_buf_pkg;

  localparam int size_width_lp = 16;

  typedef enum logic [1:0] {
    op_1b = 2'd0,
    op_2b = 2'd1,
    op_4b = 2'd2,
    op_8b = 2'd3
  } rd_op_size_e;

  // Shifts the addressed byte lane to bit 0 and zeroes everything above the access size.
  function automatic logic [63:0] lane_extract(input logic [127:0] data,
                                               input logic [3:0]   off,
                                               input rd_op_size_e  size);
    logic [127:0] shifted;
    logic [63:0]  lane;
    shifted = data >> {off, 3'b000};
    lane    = shifted[63:0];
    case (size)
      op_1b:   lane = {56'h0, lane[7:0]};
      op_2b:   lane = {48'h0, lane[15:0]};
      op_4b:   lane = {32'h0, lane[31:0]};
      default: lane = lane;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/rx_slot_tracker.sv
// Head/tail slot pointers, committed-frame occupancy, full/empty and the saturating drop counter.
// Same-cycle state update; full/empty come from registered occupancy only.
module rx_slot_tracker #(
  parameter  int slot_p       = 4,
  parameter  int drop_width_p = 16,
  localparam int ptr_w_lp     = $clog2(slot_p),
  localparam int occ_w_lp     = $clog2(slot_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    commit_v_i,
  input  logic                    abort_i,
  input  logic                    pop_i,
  output logic [ptr_w_lp-1:0]     head_o,
  output logic [ptr_w_lp-1:0]     tail_o,
  output logic [occ_w_lp-1:0]     occupancy_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    commit_take_o,
  output logic                    pop_take_o,
  output logic [drop_width_p-1:0] drop_count_o
);

  logic commit_drop;

  assign full_o        = (occupancy_o == occ_w_lp'(slot_p));
  assign empty_o       = (occupancy_o == '0);
  // Abort overrides commit entirely: neither enqueued nor counted as a drop.
  assign commit_take_o = commit_v_i & ~abort_i & ~full_o;
  assign commit_drop   = commit_v_i & ~abort_i & full_o;
  assign pop_take_o    = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      head_o       <= '0;
      tail_o       <= '0;
      occupancy_o  <= '0;
      drop_count_o <= '0;
    end else begin
      if (commit_take_o) tail_o <= tail_o + ptr_w_lp'(1);
      if (pop_take_o)    head_o <= head_o + ptr_w_lp'(1);
      occupancy_o <= occupancy_o + occ_w_lp'(commit_take_o) - occ_w_lp'(pop_take_o);
      if (commit_drop && (drop_count_o != '1))
        drop_count_o <= drop_count_o + drop_width_p'(1);
    end
  end

endmodule

// File: rtl/rx_frame_slot_buffer.sv
// Multi-slot RX frame store: MAC fills/commits the tail slot, host reads and pops the head slot.
// Read data 1 cycle after an accepted request; writes and commits are refused while all slots are full.
module rx_frame_slot_buffer
  import rx_buf_pkg::*;
#(
  parameter  int slot_p        = 4,
  parameter  int data_width_p  = 64,
  parameter  int slot_bytes_p  = 2048,
  parameter  int drop_width_p  = 16,
  localparam int addr_width_lp = $clog2(slot_bytes_p),
  localparam int bytes_lp      = data_width_p / 8,
  localparam int lsb_lp        = $clog2(bytes_lp),
  localparam int words_lp      = slot_bytes_p / bytes_lp,
  localparam int word_w_lp     = addr_width_lp - lsb_lp,
  localparam int ptr_w_lp      = $clog2(slot_p),
  localparam int occ_w_lp      = $clog2(slot_p + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     wr_v_i,
  input  logic [addr_width_lp-1:0] wr_addr_i,
  input  logic [data_width_p-1:0]  wr_data_i,
  input  logic [bytes_lp-1:0]      wr_mask_i,
  input  logic                     commit_v_i,
  input  logic [size_width_lp-1:0] commit_size_i,
  input  logic                     commit_err_i,
  input  logic                     abort_i,
  output logic                     wr_ready_o,
  output logic                     rd_slot_v_o,
  output logic [size_width_lp-1:0] rd_size_o,
  output logic                     rd_err_o,
  input  logic                     rd_pop_i,
  input  logic                     rd_v_i,
  input  logic [addr_width_lp-1:0] rd_addr_i,
  input  logic [1:0]               rd_op_size_i,
  output logic [data_width_p-1:0]  rd_data_o,
  output logic                     rd_data_v_o,
  output logic                     rd_misalign_o,
  output logic [occ_w_lp-1:0]      occupancy_o,
  output logic [drop_width_p-1:0]  drop_count_o
);

  logic [ptr_w_lp-1:0] head, tail;
  logic                full, empty, commit_take, pop_take;

  rx_slot_tracker #(
    .slot_p       (slot_p),
    .drop_width_p (drop_width_p)
  ) u_tracker (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .commit_v_i    (commit_v_i),
    .abort_i       (abort_i),
    .pop_i         (rd_pop_i),
    .head_o        (head),
    .tail_o        (tail),
    .occupancy_o   (occupancy_o),
    .full_o        (full),
    .empty_o       (empty),
    .commit_take_o (commit_take),
    .pop_take_o    (pop_take),
    .drop_count_o  (drop_count_o)
  );

  assign wr_ready_o  = ~full;
  assign rd_slot_v_o = ~empty;

  logic                 wr_en, rd_en;
  logic [word_w_lp-1:0] wr_word, rd_word;

  assign wr_en   = wr_v_i & ~full;
  assign rd_en   = rd_v_i & ~empty;
  assign wr_word = wr_addr_i[addr_width_lp-1:lsb_lp];
  assign rd_word = rd_addr_i[addr_width_lp-1:lsb_lp];

  logic [slot_p-1:0]       rd_sel_q;
  logic [data_width_p-1:0] slot_q [slot_p];

  // Head and tail never coincide while both ports are active, so each slot RAM needs one port.
  for (genvar s = 0; s < slot_p; s++) begin : g_slot
    logic [data_width_p-1:0] mem [words_lp];
    logic [data_width_p-1:0] q;

    always_ff @(posedge clk_i) begin
      if (wr_en && (tail == ptr_w_lp'(s))) begin
        for (int b = 0; b < bytes_lp; b++)
          if (wr_mask_i[b]) mem[wr_word][b*8 +: 8] <= wr_data_i[b*8 +: 8];
      end else if (rd_en && (head == ptr_w_lp'(s))) begin
        q <= mem[rd_word];
      end
    end

    assign slot_q[s] = q & {data_width_p{rd_sel_q[s]}};
  end

  logic [size_width_lp-1:0] size_q [slot_p];
  logic [slot_p-1:0]        err_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int s = 0; s < slot_p; s++) size_q[s] <= '0;
      err_q <= '0;
    end else if (commit_take) begin
      size_q[tail] <= commit_size_i;
      err_q[tail]  <= commit_err_i;
    end
  end

  assign rd_size_o = size_q[head];
  assign rd_err_o  = err_q[head];

  logic              misalign;
  logic              rd_data_v_q, rd_misalign_q;
  logic [lsb_lp-1:0] rd_off_q;
  rd_op_size_e       rd_opsz_q;

  always_comb begin
    misalign = 1'b0;
    case (rd_op_size_e'(rd_op_size_i))
      op_1b:   misalign = 1'b0;
      op_2b:   misalign = rd_addr_i[0];
      op_4b:   misalign = |rd_addr_i[1:0];
      default: misalign = |rd_addr_i[2:0];
    endcase
  end

  // Capturing the slot select here lets a same-cycle pop advance head without disturbing this read.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_data_v_q   <= 1'b0;
      rd_misalign_q <= 1'b0;
      rd_sel_q      <= '0;
      rd_off_q      <= '0;
      rd_opsz_q     <= op_1b;
    end else begin
      rd_data_v_q <= rd_en;
      if (rd_en) begin
        rd_sel_q      <= slot_p'(1) << head;
        rd_off_q      <= rd_addr_i[lsb_lp-1:0];
        rd_opsz_q     <= rd_op_size_e'(rd_op_size_i);
        rd_misalign_q <= misalign;
      end
    end
  end

  logic [data_width_p-1:0] word_sel;
  logic [63:0]             lane;

  always_comb begin
    word_sel = '0;
    for (int s = 0; s < slot_p; s++) word_sel = word_sel | slot_q[s];
    lane      = lane_extract(128'(word_sel), 4'(rd_off_q), rd_opsz_q);
    rd_data_o = '0;
    if (rd_data_v_q && !rd_misalign_q) rd_data_o = data_width_p'(lane);
  end

  assign rd_data_v_o   = rd_data_v_q;
  assign rd_misalign_o = rd_data_v_q & rd_misalign_q;

  always @(posedge clk_i) begin
    if (reset_ni) begin
      assert (!(rd_v_i && (int'(rd_op_size_i) > lsb_lp)));
      assert (!(wr_v_i && (wr_addr_i[lsb_lp-1:0] != '0)));
      assert (data_width_p == 32 || data_width_p == 64 || data_width_p == 128);
    end
  end

endmodule
